// File: rtl/sram_rr_scheduler.sv
// -----------------------------------------------------------------------------
// sram_rr_scheduler
//   Round-robin arbiter that shares one SRAM command port between two write
//   channels (W0, W1) and two read channels (R0, R1). Commands pass through a
//   single command register (CR). In-flight reads are tracked by an in-order
//   tag queue, so returned data is steered to the read channel that asked.
//
// Handshake semantics (all interfaces):
//   - FIFO side: *_valid means "FIFO not empty, head word visible"; *_ready
//     is a one-cycle pop strobe issued only in the cycle the channel is
//     granted.
//   - SRAM side: a command transfers on a rising edge where sram_addr_valid
//     and sram_ready are both 1. While valid is high and ready is low, the
//     command fields are held stable.
//
// Ports:
//   sram_clock, reset          clock, synchronous active-high reset
//   w0_*/w1_*                  write FIFOs {mask[53:50], addr[49:32], data}
//   r0_req_*/r1_req_*          read-address FIFOs
//   r0_resp_*/r1_resp_*        response FIFO write side (+ almost-full)
//   sram_*                     SRAM command / read-data port
//   err_unexpected             sticky: read data arrived with no tag queued
// -----------------------------------------------------------------------------
module sram_rr_scheduler #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        sram_clock,
  input  logic        reset,
  input  logic        w0_valid,
  output logic        w0_ready,
  input  logic [53:0] w0_data,
  input  logic        w1_valid,
  output logic        w1_ready,
  input  logic [53:0] w1_data,
  input  logic        r0_req_valid,
  output logic        r0_req_ready,
  input  logic [17:0] r0_req_addr,
  input  logic        r1_req_valid,
  output logic        r1_req_ready,
  input  logic [17:0] r1_req_addr,
  input  logic        r0_resp_afull,
  output logic        r0_resp_valid,
  output logic [31:0] r0_resp_data,
  input  logic        r1_resp_afull,
  output logic        r1_resp_valid,
  output logic [31:0] r1_resp_data,
  output logic        sram_addr_valid,
  input  logic        sram_ready,
  output logic [17:0] sram_addr,
  output logic [31:0] sram_data_in,
  output logic [3:0]  sram_write_mask,
  input  logic [31:0] sram_data_out,
  input  logic        sram_data_out_valid,
  output logic        err_unexpected
);

  localparam int TAG_AW = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W  = TAG_AW + 1;

  // Ring index: 0=W0, 1=W1, 2=R0, 3=R1. Bit 1 set means a read channel,
  // bit 0 selects channel 0/1 within the pair.
  logic [1:0]        r_ptr;
  logic              r_cr_full;
  logic [17:0]       r_cr_addr;
  logic [31:0]       r_cr_data;
  logic [3:0]        r_cr_mask;
  logic              r_tags [MAX_OUTSTANDING];
  logic [TAG_AW-1:0] r_tag_wr;
  logic [TAG_AW-1:0] r_tag_rd;
  logic [CNT_W-1:0]  r_tag_cnt;
  logic              r_resp_v0;
  logic              r_resp_v1;
  logic [31:0]       r_resp_data;
  logic              r_err;

  logic              w_loadable;
  logic              w_tag_room;
  logic [3:0]        w_elig;
  logic              w_grant_any;
  logic [1:0]        w_grant_idx;
  logic [3:0]        w_gnt;
  logic              w_is_read;
  logic [53:0]       w_wentry;
  logic [17:0]       w_raddr;
  logic              w_load;
  logic              w_push;
  logic              w_pop;
  logic              w_head_tag;

  // CR can take a new command when empty or when its current one leaves now.
  assign w_loadable = ~r_cr_full | sram_ready;
  // Occupancy is judged before this cycle's push/pop.
  assign w_tag_room = (r_tag_cnt < CNT_W'(MAX_OUTSTANDING));

  assign w_elig[0] = w0_valid;
  assign w_elig[1] = w1_valid;
  assign w_elig[2] = r0_req_valid & ~r0_resp_afull & w_tag_room;
  assign w_elig[3] = r1_req_valid & ~r1_resp_afull & w_tag_room;

  // First eligible channel at or after the pointer wins.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!w_grant_any && w_elig[r_ptr + 2'(i)]) begin
        w_grant_any = 1'b1;
        w_grant_idx = r_ptr + 2'(i);
      end
    end
    w_grant_any = w_grant_any & w_loadable & ~reset;
  end

  assign w_gnt        = w_grant_any ? (4'b0001 << w_grant_idx) : 4'b0000;
  assign w0_ready     = w_gnt[0];
  assign w1_ready     = w_gnt[1];
  assign r0_req_ready = w_gnt[2];
  assign r1_req_ready = w_gnt[3];

  assign w_is_read = w_grant_idx[1];
  assign w_wentry  = w_grant_idx[0] ? w1_data : w0_data;
  assign w_raddr   = w_grant_idx[0] ? r1_req_addr : r0_req_addr;
  // A zero-mask write is popped and consumes its turn but never reaches SRAM.
  assign w_load    = w_grant_any & (w_is_read | (w_wentry[53:50] != 4'b0000));
  assign w_push    = w_grant_any & w_is_read;
  assign w_pop     = sram_data_out_valid & (r_tag_cnt != '0);
  assign w_head_tag = r_tags[r_tag_rd];

  always_ff @(posedge sram_clock) begin
    if (reset) begin
      r_ptr       <= 2'd0;
      r_cr_full   <= 1'b0;
      r_cr_addr   <= '0;
      r_cr_data   <= '0;
      r_cr_mask   <= '0;
      r_tag_wr    <= '0;
      r_tag_rd    <= '0;
      r_tag_cnt   <= '0;
      r_resp_v0   <= 1'b0;
      r_resp_v1   <= 1'b0;
      r_resp_data <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_grant_any) begin
        r_ptr <= w_grant_idx + 2'd1;
      end
      if (w_loadable) begin
        r_cr_full <= w_load;
        if (w_load) begin
          if (w_is_read) begin
            r_cr_addr <= w_raddr;
            r_cr_data <= 32'd0;
            r_cr_mask <= 4'b0000;
          end else begin
            r_cr_addr <= w_wentry[49:32];
            r_cr_data <= w_wentry[31:0];
            r_cr_mask <= w_wentry[53:50];
          end
        end
      end
      case ({w_push, w_pop})
        2'b10:   r_tag_cnt <= r_tag_cnt + CNT_W'(1);
        2'b01:   r_tag_cnt <= r_tag_cnt - CNT_W'(1);
        default: r_tag_cnt <= r_tag_cnt;
      endcase
      if (w_push) begin
        r_tag_wr <= r_tag_wr + TAG_AW'(1);
      end
      if (w_pop) begin
        r_tag_rd <= r_tag_rd + TAG_AW'(1);
      end
      r_resp_v0 <= w_pop & ~w_head_tag;
      r_resp_v1 <= w_pop & w_head_tag;
      if (sram_data_out_valid) begin
        r_resp_data <= sram_data_out;
      end
      if (sram_data_out_valid && (r_tag_cnt == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

  // Tag storage needs no reset: entries are only read behind the count.
  always_ff @(posedge sram_clock) begin
    if (w_push) begin
      r_tags[r_tag_wr] <= w_grant_idx[0];
    end
  end

  assign sram_addr_valid = r_cr_full;
  assign sram_addr       = r_cr_addr;
  assign sram_data_in    = r_cr_data;
  assign sram_write_mask = r_cr_mask;
  assign r0_resp_valid   = r_resp_v0;
  assign r1_resp_valid   = r_resp_v1;
  assign r0_resp_data    = r_resp_data;
  assign r1_resp_data    = r_resp_data;
  assign err_unexpected  = r_err;

endmodule

// File: tb/tb_sram_rr_scheduler.sv
module tb_sram_rr_scheduler;

  localparam int MAXO = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        sram_clock = 1'b0;
  logic        reset;
  logic        w0_valid, w0_ready, w1_valid, w1_ready;
  logic [53:0] w0_data, w1_data;
  logic        r0_req_valid, r0_req_ready, r1_req_valid, r1_req_ready;
  logic [17:0] r0_req_addr, r1_req_addr;
  logic        r0_resp_afull, r0_resp_valid, r1_resp_afull, r1_resp_valid;
  logic [31:0] r0_resp_data, r1_resp_data;
  logic        sram_addr_valid, sram_ready;
  logic [17:0] sram_addr;
  logic [31:0] sram_data_in;
  logic [3:0]  sram_write_mask;
  logic [31:0] sram_data_out;
  logic        sram_data_out_valid;
  logic        err_unexpected;

  always #5 sram_clock = ~sram_clock;

  sram_rr_scheduler #(.MAX_OUTSTANDING(MAXO)) dut (
    .sram_clock(sram_clock), .reset(reset),
    .w0_valid(w0_valid), .w0_ready(w0_ready), .w0_data(w0_data),
    .w1_valid(w1_valid), .w1_ready(w1_ready), .w1_data(w1_data),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_addr(r0_req_addr),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_addr(r1_req_addr),
    .r0_resp_afull(r0_resp_afull), .r0_resp_valid(r0_resp_valid), .r0_resp_data(r0_resp_data),
    .r1_resp_afull(r1_resp_afull), .r1_resp_valid(r1_resp_valid), .r1_resp_data(r1_resp_data),
    .sram_addr_valid(sram_addr_valid), .sram_ready(sram_ready), .sram_addr(sram_addr),
    .sram_data_in(sram_data_in), .sram_write_mask(sram_write_mask),
    .sram_data_out(sram_data_out), .sram_data_out_valid(sram_data_out_valid),
    .err_unexpected(err_unexpected)
  );

  // ---------------- environment state ----------------
  logic [53:0] wq0[$], wq1[$];
  logic [17:0] rq0[$], rq1[$];
  int          pend_due[$];
  logic [31:0] pend_data[$];
  int          cyc, last_due;
  int          rdy_pct, af_pct, lat_max;
  bit          ret_en, ret_once, spur, drove_ret;
  logic [31:0] spur_data;

  // ---------------- reference model ----------------
  int          m_ptr;
  bit          m_cr_full;
  logic [17:0] m_cr_addr;
  logic [31:0] m_cr_data;
  logic [3:0]  m_cr_mask;
  int          m_tags[$];
  bit          m_resp_v[2];
  logic [31:0] m_resp_d;
  bit          m_err;
  int          e_win;

  // ---------------- observation logs ----------------
  int          obs_rdy[4];
  int          obs_av;
  int          obs_resp_cnt[2];
  int          obs_resp_ch[$];
  logic [31:0] obs_resp_data[$];
  logic [31:0] sent_q[$];
  int          gseq[$];

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_cr_full = 0; m_cr_addr = '0; m_cr_data = '0; m_cr_mask = '0;
    m_tags.delete(); m_resp_v[0] = 0; m_resp_v[1] = 0; m_resp_d = '0; m_err = 0;
    pend_due.delete(); pend_data.delete();
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 4; i++) obs_rdy[i] = 0;
    obs_av = 0; obs_resp_cnt[0] = 0; obs_resp_cnt[1] = 0;
    obs_resp_ch.delete(); obs_resp_data.delete(); sent_q.delete(); gseq.delete();
  endtask

  task automatic cfg(input int rdy, input int af, input bit ren, input int lat);
    rdy_pct = rdy; af_pct = af; ret_en = ren; lat_max = lat;
  endtask

  // ---------------- driver ----------------
  task automatic drive_inputs();
    w0_valid     = (wq0.size() != 0); w0_data = w0_valid ? wq0[0] : '0;
    w1_valid     = (wq1.size() != 0); w1_data = w1_valid ? wq1[0] : '0;
    r0_req_valid = (rq0.size() != 0); r0_req_addr = r0_req_valid ? rq0[0] : '0;
    r1_req_valid = (rq1.size() != 0); r1_req_addr = r1_req_valid ? rq1[0] : '0;
    sram_ready    = ($urandom_range(99) < rdy_pct);
    r0_resp_afull = ($urandom_range(99) < af_pct);
    r1_resp_afull = ($urandom_range(99) < af_pct);
    sram_data_out_valid = 1'b0;
    sram_data_out = $urandom;
    drove_ret = 0;
    if (spur) begin
      sram_data_out_valid = 1'b1; sram_data_out = spur_data; spur = 0;
    end else if (pend_due.size() > 0 && (ret_once || (ret_en && pend_due[0] <= cyc))) begin
      sram_data_out_valid = 1'b1; sram_data_out = pend_data[0];
      drove_ret = 1; ret_once = 0;
    end
    if (sram_data_out_valid) sent_q.push_back(sram_data_out);
  endtask

  // Expected outputs for the current cycle, plus observation logging.
  task automatic check_outputs();
    bit elig[4];
    bit loadable;
    elig[0] = w0_valid; elig[1] = w1_valid;
    elig[2] = r0_req_valid && !r0_resp_afull && (m_tags.size() < MAXO);
    elig[3] = r1_req_valid && !r1_resp_afull && (m_tags.size() < MAXO);
    loadable = !m_cr_full || sram_ready;
    e_win = -1;
    if (!reset && loadable)
      for (int i = 0; i < 4; i++)
        if (e_win < 0 && elig[(m_ptr + i) % 4]) e_win = (m_ptr + i) % 4;
    chk("w0_ready", w0_ready, e_win == 0);
    chk("w1_ready", w1_ready, e_win == 1);
    chk("r0_req_ready", r0_req_ready, e_win == 2);
    chk("r1_req_ready", r1_req_ready, e_win == 3);
    chk("sram_addr_valid", sram_addr_valid, m_cr_full);
    if (m_cr_full) begin
      chk("sram_addr", sram_addr, m_cr_addr);
      chk("sram_data_in", sram_data_in, m_cr_data);
      chk("sram_write_mask", sram_write_mask, m_cr_mask);
    end
    chk("r0_resp_valid", r0_resp_valid, m_resp_v[0]);
    chk("r1_resp_valid", r1_resp_valid, m_resp_v[1]);
    if (m_resp_v[0]) chk("r0_resp_data", r0_resp_data, m_resp_d);
    if (m_resp_v[1]) chk("r1_resp_data", r1_resp_data, m_resp_d);
    chk("err_unexpected", err_unexpected, m_err);
    if (w0_ready) begin obs_rdy[0]++; gseq.push_back(0); end
    if (w1_ready) begin obs_rdy[1]++; gseq.push_back(1); end
    if (r0_req_ready) begin obs_rdy[2]++; gseq.push_back(2); end
    if (r1_req_ready) begin obs_rdy[3]++; gseq.push_back(3); end
    if (sram_addr_valid) obs_av++;
    if (r0_resp_valid) begin
      obs_resp_cnt[0]++; obs_resp_ch.push_back(0); obs_resp_data.push_back(r0_resp_data);
    end
    if (r1_resp_valid) begin
      obs_resp_cnt[1]++; obs_resp_ch.push_back(1); obs_resp_data.push_back(r1_resp_data);
    end
  endtask

  // Advance the model by one clock edge using this cycle's inputs.
  task automatic update_model();
    logic [53:0] ent;
    logic [17:0] ra;
    int due;
    if (drove_ret) begin void'(pend_due.pop_front()); void'(pend_data.pop_front()); end
    if (reset) begin model_reset(); cyc++; return; end
    // SRAM accepts a read command: schedule its in-order return.
    if (m_cr_full && sram_ready && m_cr_mask == 4'b0000) begin
      due = cyc + 1 + $urandom_range(lat_max - 1);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_due.push_back(due); pend_data.push_back($urandom);
    end
    if (!m_cr_full || sram_ready) m_cr_full = 0;
    m_resp_v[0] = 0; m_resp_v[1] = 0;
    if (sram_data_out_valid) begin
      if (m_tags.size() > 0) begin
        m_resp_v[m_tags.pop_front()] = 1;
        m_resp_d = sram_data_out;
      end else begin
        m_err = 1;
      end
    end
    if (e_win >= 0) begin
      m_ptr = (e_win + 1) % 4;
      if (e_win < 2) begin
        ent = (e_win == 0) ? wq0.pop_front() : wq1.pop_front();
        if (ent[53:50] != 4'b0000) begin
          m_cr_full = 1; m_cr_mask = ent[53:50]; m_cr_addr = ent[49:32]; m_cr_data = ent[31:0];
        end
      end else begin
        ra = (e_win == 2) ? rq0.pop_front() : rq1.pop_front();
        m_cr_full = 1; m_cr_mask = 4'b0000; m_cr_addr = ra; m_cr_data = 32'd0;
        m_tags.push_back(e_win - 2);
      end
    end
    cyc++;
  endtask

  task automatic step();
    drive_inputs();
    @(negedge sram_clock);
    check_outputs();
    @(posedge sram_clock);
    update_model();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    wq0.delete(); wq1.delete(); rq0.delete(); rq1.delete();
    spur = 0; ret_once = 0;
    run(2);
    reset = 1'b0;
  endtask

  function automatic logic [53:0] rand_wentry(input bit nonzero_mask);
    logic [3:0] m;
    m = nonzero_mask ? 4'($urandom_range(15, 1)) : 4'($urandom_range(15));
    return {m, 18'($urandom), 32'($urandom)};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    cyc = 0; last_due = 0; spur = 0; ret_once = 0; drove_ret = 0; spur_data = '0;
    reset = 1'b1;
    w0_valid = 0; w1_valid = 0; r0_req_valid = 0; r1_req_valid = 0;
    w0_data = '0; w1_data = '0; r0_req_addr = '0; r1_req_addr = '0;
    r0_resp_afull = 0; r1_resp_afull = 0; sram_ready = 0;
    sram_data_out = '0; sram_data_out_valid = 0;
    model_reset(); clear_obs();
    cfg(100, 0, 1, 2);
    @(posedge sram_clock); #1;

    // Reset state
    reset_dut();
    chk("rst_addr_valid", sram_addr_valid, 0);
    chk("rst_err", err_unexpected, 0);
    chk("rst_resp", {r0_resp_valid, r1_resp_valid}, 0);

    // Single W0 write
    cfg(100, 0, 1, 2); clear_obs();
    wq0.push_back({4'hF, 18'h00010, 32'hDEADBEEF});
    run(4);
    chk("single_w0_pulses", obs_rdy[0], 1);
    chk("single_cmds", obs_av, 1);

    // All four channels busy: strict rotation, back-to-back issue
    reset_dut(); cfg(100, 0, 1, 2); clear_obs();
    for (int i = 0; i < 8; i++) begin
      wq0.push_back(rand_wentry(1)); wq1.push_back(rand_wentry(1));
      rq0.push_back(18'($urandom)); rq1.push_back(18'($urandom));
    end
    run(12);
    chk("rr_grants", gseq.size(), 12);
    for (int i = 0; i < gseq.size(); i++) chk("rr_order", gseq[i], i % 4);
    chk("rr_cmds", obs_av, 11);

    // SRAM backpressure with CR full
    reset_dut(); cfg(100, 0, 1, 2);
    for (int i = 0; i < 3; i++) wq0.push_back(rand_wentry(1));
    run(1);
    cfg(0, 0, 1, 2); clear_obs();
    run(5);
    chk("stall_pulses", obs_rdy[0], 0);
    chk("stall_valid", obs_av, 5);
    cfg(100, 0, 1, 2); clear_obs();
    run(3);
    chk("stall_resume", obs_rdy[0], 2);

    // Outstanding limit on R0
    reset_dut(); cfg(100, 0, 0, 2); clear_obs();
    for (int i = 0; i < 6; i++) rq0.push_back(18'(i + 1));
    run(10);
    chk("outst_pulses", obs_rdy[2], MAXO);
    clear_obs();
    if (pend_data.size() > 0) pend_data[0] = 32'h12345678;
    ret_once = 1;
    run(4);
    chk("outst_more", obs_rdy[2], 1);
    chk("outst_resp_cnt", obs_resp_cnt[0], 1);
    if (obs_resp_data.size() > 0) chk("outst_resp_data", obs_resp_data[0], 32'h12345678);
    else chk("outst_resp_data", 0, 32'h12345678);

    // R1 then R0: responses routed in issue order
    reset_dut(); cfg(100, 0, 1, 3); clear_obs();
    rq1.push_back(18'h00020);
    run(1);
    rq0.push_back(18'h00030);
    run(8);
    chk("inter_resp_n", obs_resp_ch.size(), 2);
    if (obs_resp_ch.size() == 2 && sent_q.size() == 2) begin
      chk("inter_first_ch", obs_resp_ch[0], 1);
      chk("inter_second_ch", obs_resp_ch[1], 0);
      chk("inter_first_data", obs_resp_data[0], sent_q[0]);
      chk("inter_second_data", obs_resp_data[1], sent_q[1]);
    end

    // Zero-mask write, then unexpected read data
    reset_dut(); cfg(100, 0, 1, 2); clear_obs();
    wq1.push_back({4'h0, 18'h00055, 32'h00000001});
    run(3);
    chk("zmask_pulse", obs_rdy[1], 1);
    chk("zmask_no_cmd", obs_av, 0);
    spur = 1; spur_data = 32'hCAFE0001; clear_obs();
    run(4);
    chk("spur_err", err_unexpected, 1);
    chk("spur_no_resp", obs_resp_cnt[0] + obs_resp_cnt[1], 0);
    reset_dut();
    chk("spur_err_clr", err_unexpected, 0);

    // Randomized traffic with a mid-run reset
    cfg(75, 15, 1, 5);
    for (int c = 0; c < 800; c++) begin
      if (c == 400) begin reset_dut(); cfg(75, 15, 1, 5); end
      if (wq0.size() < 4 && $urandom_range(2) == 0) wq0.push_back(rand_wentry(0));
      if (wq1.size() < 4 && $urandom_range(2) == 0) wq1.push_back(rand_wentry(0));
      if (rq0.size() < 4 && $urandom_range(1) == 0) rq0.push_back(18'($urandom));
      if (rq1.size() < 4 && $urandom_range(1) == 0) rq1.push_back(18'($urandom));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
